dmem_arbiter: RTL

- Shares the single-port data SRAM (7-bit word address, 32-bit data, active-low CEN/WEN/OEN) between two requesters.
  - Port 0: the MIPS core's load/store path.
  - Port 1: the host/test loader that preloads and dumps data memory.
- Arbitrates every cycle and supports locked bursts with a starvation limit.
- Drives registered SRAM controls and returns read data with a fixed latency.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data SRAM between the core (port 0) and the host loader (port 1).
// Latency: SRAM controls are registered one cycle after a beat; read data returns two cycles after the beat.
// Backpressure: pX_ready is a combinational grant; the losing/non-owner port stalls. DMEM_ARB_RR_EN = round-robin ties.
module dmem_arbiter #(
   parameter int AW        = 7,
   parameter int DW        = 32,
   parameter int MAX_BURST = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_valid,
   input  logic          p0_we,
   input  logic          p0_lock,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_ready,
   output logic          p0_rvalid,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_valid,
   input  logic          p1_we,
   input  logic          p1_lock,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_ready,
   output logic          p1_rvalid,
   output logic [DW-1:0] p1_rdata,
   output logic          CEN,
   output logic          WEN,
   output logic          OEN,
   output logic [AW-1:0] A,
   output logic [DW-1:0] D,
   input  logic [DW-1:0] Q
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state, state_nxt;
   logic [3:0]    burst_cnt, burst_cnt_nxt;
   logic          rr_ptr, rr_ptr_nxt;
   logic          gnt0, gnt1;
   logic          tie;
   logic          beat, beat_port, beat_we, beat_lock;
   logic [AW-1:0] beat_addr;
   logic [DW-1:0] beat_wdata;
   logic [4:0]    cnt_inc;
   logic          limit;
   logic          rd_pend, rd_port;

   assign tie = (state == IDLE) && p0_valid && p1_valid;

   // Grants already include valid, so a grant is an accepted beat.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         IDLE: begin
            if (tie) begin
               gnt0 = !rr_ptr;
               gnt1 = rr_ptr;
            end else begin
               gnt0 = p0_valid;
               gnt1 = p1_valid;
            end
         end
         OWN0:    gnt0 = p0_valid;
         OWN1:    gnt1 = p1_valid;
         default: ;
      endcase
   end

   assign p0_ready   = gnt0;
   assign p1_ready   = gnt1;
   assign beat       = gnt0 | gnt1;
   assign beat_port  = gnt1;
   assign beat_we    = beat_port ? p1_we    : p0_we;
   assign beat_lock  = beat_port ? p1_lock  : p0_lock;
   assign beat_addr  = beat_port ? p1_addr  : p0_addr;
   assign beat_wdata = beat_port ? p1_wdata : p0_wdata;
   assign cnt_inc    = {1'b0, burst_cnt} + 5'd1;
   assign limit      = (cnt_inc >= 5'(MAX_BURST));

   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      rr_ptr_nxt    = rr_ptr;
      if (beat) begin
         if (beat_lock && !limit) begin
            state_nxt     = beat_port ? OWN1 : OWN0;
            burst_cnt_nxt = cnt_inc[3:0];
         end else begin
            state_nxt     = IDLE;
            burst_cnt_nxt = 4'd0;
         end
`ifdef DMEM_ARB_RR_EN
         rr_ptr_nxt = !beat_port;
`else
         // A forced release favours the other port for exactly one tie.
         if (tie)
            rr_ptr_nxt = 1'b0;
`endif
         if (beat_lock && limit)
            rr_ptr_nxt = !beat_port;
      end else if ((state == OWN0 && !p0_valid && !p0_lock) ||
                   (state == OWN1 && !p1_valid && !p1_lock)) begin
         state_nxt     = IDLE;
         burst_cnt_nxt = 4'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         burst_cnt <= 4'd0;
         rr_ptr    <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         rr_ptr    <= rr_ptr_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         CEN <= 1'b1;
         WEN <= 1'b1;
         A   <= '0;
         D   <= '0;
      end else begin
         CEN <= !beat;
         if (beat) begin
            WEN <= !beat_we;
            A   <= beat_addr;
            D   <= beat_wdata;
         end else begin
            WEN <= 1'b1;
         end
      end
   end

   // Owner tag follows the read through the SRAM's one-cycle output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend   <= 1'b0;
         rd_port   <= 1'b0;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
      end else begin
         rd_pend   <= beat && !beat_we;
         rd_port   <= beat_port;
         p0_rvalid <= rd_pend && !rd_port;
         p1_rvalid <= rd_pend && rd_port;
      end
   end

   assign OEN      = 1'b0;
   assign p0_rdata = Q;
   assign p1_rdata = Q;

endmodule
